// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: shares the SRAM frame buffer between queued draw writes and scanout reads,
// and toggles the back buffer only after every queued draw write has landed.
module frame_buffer_arbiter #(
  parameter int ADDR_BITS    = 16,
  parameter int DATA_BITS    = 24,
  parameter int FIFO_DEPTH   = 4,
  parameter int RD_BURST_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_req_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [DATA_BITS-1:0] wr_data_i,
  output logic                 wr_ready_o,
  input  logic                 rd_req_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic                 rd_ack_o,
  output logic [DATA_BITS-1:0] rd_data_o,
  output logic                 rd_valid_o,
  input  logic                 swap_req_i,
  output logic                 swap_done_o,
  output logic                 CE0_o,
  output logic                 CE1_o,
  output logic                 R_W_o,
  output logic                 OE_o,
  output logic                 LB_o,
  output logic                 UB_o,
  output logic                 ZZ_o,
  output logic                 SEM_o,
  output logic [ADDR_BITS:0]   adddataout_o,
  output logic [DATA_BITS-1:0] rgbdataout_o,
  input  logic [DATA_BITS-1:0] rdata_i,
  output logic                 buffer_select_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(RD_BURST_MAX + 1);
  typedef enum logic [2:0] {IDLE, WRITE, READ, RECOVER, SWAP} state_t;
  state_t state_q, state_d, grant;
  logic [ADDR_BITS-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] burst_q, burst_d;
  logic swap_pending_q, swap_pending_d, buffer_select_q, buffer_select_d;
  logic swap_done_q, swap_done_d, rd_valid_q, rd_valid_d;
  logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic push, pop, empty, full, arb, wr_cyc, rd_cyc, burst_max;
  always_comb begin
    wr_cyc = state_q == WRITE;
    rd_cyc = state_q == READ;
    arb = state_q == IDLE || state_q == RECOVER;
    empty = count_q == '0;
    full = count_q == CW'(FIFO_DEPTH);
    burst_max = burst_q == BW'(RD_BURST_MAX);
    wr_ready_o = !full && !swap_pending_q;
    push = wr_req_i && wr_ready_o;
    pop = wr_cyc;
    // swap waits for an empty FIFO; a saturated read burst hands the next slot to a pending write
    grant = swap_pending_q && empty ? SWAP :
            !empty && burst_max ? WRITE :
            rd_req_i ? READ :
            !empty ? WRITE : IDLE;
    state_d = arb ? grant : (wr_cyc || rd_cyc) ? RECOVER : IDLE;
    burst_d = !arb || grant == IDLE || grant == SWAP ? burst_q :
              grant == WRITE || empty ? '0 :
              burst_max ? burst_q : burst_q + 1'b1;
    count_d = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    swap_pending_d = state_q == SWAP ? 1'b0 : swap_pending_q || swap_req_i;
    buffer_select_d = buffer_select_q ^ (state_q == SWAP);
    swap_done_d = state_q == SWAP;
    rd_valid_d = rd_cyc;
    rd_data_d = rd_cyc ? rdata_i : rd_data_q;
    CE0_o = !(wr_cyc || rd_cyc);
    CE1_o = wr_cyc || rd_cyc;
    R_W_o = !wr_cyc;
    OE_o = !rd_cyc;
    LB_o = 1'b0;
    UB_o = 1'b0;
    ZZ_o = 1'b0;
    SEM_o = 1'b1;
    adddataout_o = wr_cyc ? {buffer_select_q, fifo_addr_q[rd_ptr_q]} :
                   rd_cyc ? {~buffer_select_q, rd_addr_i} : '0;
    rgbdataout_o = wr_cyc ? fifo_data_q[rd_ptr_q] : '0;
    rd_ack_o = rd_cyc;
    rd_data_o = rd_data_q;
    rd_valid_o = rd_valid_q;
    swap_done_o = swap_done_q;
    buffer_select_o = buffer_select_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      burst_q <= '0;
      swap_pending_q <= 1'b0;
      buffer_select_q <= 1'b0;
      swap_done_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      burst_q <= burst_d;
      swap_pending_q <= swap_pending_d;
      buffer_select_q <= buffer_select_d;
      swap_done_q <= swap_done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q <= rd_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr_i;
      fifo_data_q[wr_ptr_q] <= wr_data_i;
    end
  end
endmodule
